sim_run_controller: RTL and testbench
=====================================

// Module: sim_run_controller
// PURPOSE
//  Synthesisable run/end-of-simulation controller for the top-level bench and FPGA emulation.
//  Sequences DUT reset, watches N monitor channels for halt, and stops on global timeout,
//  commit-stall watchdog or monitor error, with an error drain window. Reports a terminal status code.
//  Generalises the fixed 8-channel any-halt/timeout loop: parametrised channel count,
//  any/all halt quorum, stall watchdog and configurable drain.
// PARAMETERS
//  NCH          8         number of monitor/retire channels
//  RST_CYCLES   2         cycles dut_rst is held after rst release (>=1)
//  TIMEOUT      10000000  RUN-cycle budget before TIMEOUT status (>=1)
//  STALL_LIMIT  100000    consecutive RUN cycles with no commit before STALL; 0 disables
//  DRAIN        5         cycles between error detection and done (>=0)
//  HALT_ALL     0         0: any channel halt ends run; 1: every channel must have halted (sticky)
//  CW           32        width of cycle_count
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous reset, active-high
//  halt          in   NCH      per-channel halt indication (valid in RUN only)
//  commit_valid  in   NCH      per-channel retire strobe (feeds stall watchdog)
//  error_in      in   1        monitor error, level or pulse
//  dut_rst       out  1        registered reset to DUT
//  running       out  1        1 while state==RUN
//  done          out  1        1 in DONE; bench calls $finish on first rising edge
//  status        out  3        sim_status_e: 0 RUNNING,1 HALT_OK,2 TIMEOUT,3 STALL,4 ERROR
//  cycle_count   out  CW       RUN cycles elapsed, saturating at all-ones
// BEHAVIOUR
//  Reset (rst=1, async): state=RESET_HOLD, dut_rst=1, running=0, done=0, status=RUNNING,
//   cycle_count=0, stall/drain/hold counters=0, halt_seen=0.
//  RESET_HOLD: hold counter increments each clk; after RST_CYCLES edges dut_rst<=0, state<=RUN.
//   halt/commit/error ignored. RST_CYCLES=2 -> dut_rst low at 3rd posedge after rst falls.
//  RUN: each cycle cycle_count++ (saturating). Stall counter cleared when |commit_valid,
//   else incremented. Events evaluated on the same edge; priority ERROR > HALT > STALL > TIMEOUT:
//   - ERROR: error_in=1 -> status<=ERROR; DRAIN==0 -> DONE, else DRAIN.
//   - HALT: HALT_ALL=0: |halt. HALT_ALL=1: halt_seen|=halt; fires when (halt_seen|halt) all ones.
//     -> status<=HALT_OK, state<=DONE.
//   - STALL: STALL_LIMIT!=0, no commit this cycle, stall counter==STALL_LIMIT-1 -> STALL, DONE.
//   - TIMEOUT: cycle_count==TIMEOUT-1 this cycle -> TIMEOUT, DONE.
//   A commit in the stall-limit cycle prevents STALL. Halt in the TIMEOUT-th cycle wins (HALT_OK).
//  DRAIN: counts DRAIN cycles, then DONE. All inputs ignored; status stays ERROR; cycle_count frozen.
//  DONE: terminal until rst. done=1, running=0, status and cycle_count held.
//  dut_rst stays 0 after RESET_HOLD. rst mid-run or mid-drain: immediate async return to reset values.
//  Latency: event on cycle n -> done=1 after posedge n+1 (n+1+DRAIN for ERROR).
//  Status is written once, on leaving RUN; never changes afterwards.
// STRUCTURE
//  Package sim_ctrl_pkg: sim_status_e (3-bit enum above), run_state_e {RESET_HOLD,RUN,DRAIN,DONE}.
//  Sub-module sat_counter #(W): clr, inc, saturating q; used for cycle, stall, hold and drain counts.
//  One 2-process FSM (async-reset state reg + comb next-state/event priority).
// TESTING
//  1 NCH=8,HALT_ALL=0: commit every cycle, halt[5]=1 at RUN cycle 40 -> status=1, done next edge, cycle_count=41.
//  2 HALT_ALL=1,NCH=4: halt[0]@10, halt[2]@20, halt[1]@30 -> running; halt[3]@35 -> status=1.
//  3 TIMEOUT=100, STALL_LIMIT=0, no halt -> done after RUN cycle 100, status=2, cycle_count=100.
//  4 STALL_LIMIT=16: commits stop at cycle 50 -> status=3 at cycle 65; commit at 65 instead -> keeps running.
//  5 DRAIN=5: error_in pulse @ cycle 20, halt @ 22 -> done exactly 6 edges later, status=4.
//  6 Same-cycle error+halt -> ERROR. rst pulse in DRAIN -> dut_rst=1, status=0, RUN after RST_CYCLES.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared types for the simulation run controller: terminal status codes,
// controller states and a counter-width helper.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUNNING = 3'd0,
    ST_HALT_OK = 3'd1,
    ST_TIMEOUT = 3'd2,
    ST_STALL   = 3'd3,
    ST_ERROR   = 3'd4
  } sim_status_e;

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_DRAIN      = 2'd2,
    S_DONE       = 2'd3
  } run_state_e;

  // Bits needed to hold the value n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sim_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sim_run_controller.sv
// Run/end-of-simulation controller: sequences DUT reset, watches halt, stall,
// timeout and error conditions, and latches a terminal status code.
module sim_run_controller
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NCH         = 8,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 10000000,
  parameter int unsigned STALL_LIMIT = 100000,
  parameter int unsigned DRAIN       = 5,
  parameter bit          HALT_ALL    = 1'b0,
  parameter int unsigned CW          = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] halt,
  input  logic [NCH-1:0] commit_valid,
  input  logic           error_in,
  output logic           dut_rst,
  output logic           running,
  output logic           done,
  output logic [2:0]     status,
  output logic [CW-1:0]  cycle_count
);

  localparam int unsigned HW          = cnt_width(RST_CYCLES);
  localparam int unsigned SW          = cnt_width(STALL_LIMIT);
  localparam int unsigned DW          = cnt_width(DRAIN);
  localparam int unsigned STALL_LAST  = (STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0;
  localparam int unsigned DRAIN_LAST  = (DRAIN > 0) ? DRAIN - 1 : 0;

  run_state_e     state_q, state_d;
  sim_status_e    status_q, status_d;
  logic           dut_rst_q, dut_rst_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic [NCH-1:0] halt_seen_q, halt_seen_d;

  logic [HW-1:0]  hold_cnt;
  logic [SW-1:0]  stall_cnt;
  logic [DW-1:0]  drain_cnt;
  logic [CW-1:0]  cycle_cnt;

  logic any_commit, in_run;
  logic err_hit, halt_hit, stall_hit, timeout_hit;

  assign in_run     = (state_q == S_RUN);
  assign any_commit = |commit_valid;

  sat_counter #(.W(HW)) u_hold_cnt (
    .clk (clk), .rst (rst), .clr (1'b0),
    .inc (state_q == S_RESET_HOLD), .q (hold_cnt)
  );

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk (clk), .rst (rst), .clr (1'b0),
    .inc (in_run), .q (cycle_cnt)
  );

  sat_counter #(.W(SW)) u_stall_cnt (
    .clk (clk), .rst (rst), .clr (!in_run || any_commit),
    .inc (in_run), .q (stall_cnt)
  );

  sat_counter #(.W(DW)) u_drain_cnt (
    .clk (clk), .rst (rst), .clr (1'b0),
    .inc (state_q == S_DRAIN), .q (drain_cnt)
  );

  assign err_hit     = error_in;
  assign halt_hit    = HALT_ALL ? (&(halt_seen_q | halt)) : (|halt);
  assign stall_hit   = (STALL_LIMIT != 0) && !any_commit && (stall_cnt == SW'(STALL_LAST));
  // Wide compare so a budget beyond the saturating counter range never fires.
  assign timeout_hit = (64'(cycle_cnt) == (64'(TIMEOUT) - 64'd1));

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    halt_seen_d = halt_seen_q;
    unique case (state_q)
      // Leaving on hold==RST_CYCLES drops dut_rst on posedge RST_CYCLES+1 after rst.
      S_RESET_HOLD: begin
        if (hold_cnt == HW'(RST_CYCLES)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        halt_seen_d = halt_seen_q | halt;
        if (err_hit) begin
          status_d = ST_ERROR;
          state_d  = (DRAIN == 0) ? S_DONE : S_DRAIN;
        end else if (halt_hit) begin
          status_d = ST_HALT_OK;
          state_d  = S_DONE;
        end else if (stall_hit) begin
          status_d = ST_STALL;
          state_d  = S_DONE;
        end else if (timeout_hit) begin
          status_d = ST_TIMEOUT;
          state_d  = S_DONE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DW'(DRAIN_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RESET_HOLD;
      end
    endcase
    dut_rst_d = (state_d == S_RESET_HOLD);
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET_HOLD;
      status_q    <= ST_RUNNING;
      dut_rst_q   <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      halt_seen_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      dut_rst_q   <= dut_rst_d;
      running_q   <= running_d;
      done_q      <= done_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  assign dut_rst     = dut_rst_q;
  assign running     = running_q;
  assign done        = done_q;
  assign status      = status_q;
  assign cycle_count = cycle_cnt;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: two instances cover any/all halt quorum,
// timeout, stall watchdog, error drain, saturation and mid-drain reset.
module tb_sim_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, err_a, dut_rst_a, running_a, done_a;
  logic [7:0]  halt_a, commit_a;
  logic [2:0]  status_a;
  logic [31:0] cyc_a;

  logic        rst_b, err_b, dut_rst_b, running_b, done_b;
  logic [3:0]  halt_b, commit_b;
  logic [2:0]  status_b;
  logic [5:0]  cyc_b;

  sim_run_controller #(
    .NCH(8), .RST_CYCLES(2), .TIMEOUT(100), .STALL_LIMIT(16),
    .DRAIN(5), .HALT_ALL(1'b0), .CW(32)
  ) dut_a (
    .clk(clk), .rst(rst_a), .halt(halt_a), .commit_valid(commit_a),
    .error_in(err_a), .dut_rst(dut_rst_a), .running(running_a),
    .done(done_a), .status(status_a), .cycle_count(cyc_a)
  );

  sim_run_controller #(
    .NCH(4), .RST_CYCLES(1), .TIMEOUT(1000), .STALL_LIMIT(0),
    .DRAIN(0), .HALT_ALL(1'b1), .CW(6)
  ) dut_b (
    .clk(clk), .rst(rst_b), .halt(halt_b), .commit_valid(commit_b),
    .error_in(err_b), .dut_rst(dut_rst_b), .running(running_b),
    .done(done_b), .status(status_b), .cycle_count(cyc_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves dut_a at the start of RUN cycle 0.
  task automatic reset_a();
    rst_a = 1'b1; halt_a = '0; commit_a = '1; err_a = 1'b0;
    step(1);
    check("a_rst_dut_rst", 32'(dut_rst_a), 1);
    check("a_rst_done", 32'(done_a), 0);
    check("a_rst_status", 32'(status_a), 0);
    rst_a = 1'b0;
    step(2);
    check("a_hold_dut_rst", 32'(dut_rst_a), 1);
    step(1);
    check("a_run_dut_rst", 32'(dut_rst_a), 0);
    check("a_run_running", 32'(running_a), 1);
    check("a_run_cyc0", cyc_a, 0);
  endtask

  task automatic reset_b();
    rst_b = 1'b1; halt_b = '0; commit_b = '0; err_b = 1'b0;
    step(1);
    check("b_rst_dut_rst", 32'(dut_rst_b), 1);
    rst_b = 1'b0;
    step(1);
    check("b_hold_dut_rst", 32'(dut_rst_b), 1);
    step(1);
    check("b_run_dut_rst", 32'(dut_rst_b), 0);
    check("b_run_running", 32'(running_b), 1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    halt_a = '0; commit_a = '1; err_a = 1'b0;
    halt_b = '0; commit_b = '0; err_b = 1'b0;
    check("a_init_cyc", cyc_a, 0);

    // Any-halt on channel 5 in RUN cycle 40
    reset_a();
    step(40);
    check("t1_running", 32'(running_a), 1);
    check("t1_cyc40", cyc_a, 40);
    halt_a = 8'h20;
    step(1);
    halt_a = '0;
    check("t1_done", 32'(done_a), 1);
    check("t1_running_off", 32'(running_a), 0);
    check("t1_status", 32'(status_a), 1);
    check("t1_cyc", cyc_a, 41);
    step(3);
    check("t1_status_held", 32'(status_a), 1);
    check("t1_cyc_held", cyc_a, 41);

    // Timeout after 100 RUN cycles
    reset_a();
    step(99);
    check("t3_running99", 32'(running_a), 1);
    step(1);
    check("t3_done", 32'(done_a), 1);
    check("t3_status", 32'(status_a), 2);
    check("t3_cyc", cyc_a, 100);

    // Halt in the timeout cycle wins
    reset_a();
    step(99);
    halt_a = 8'h01;
    step(1);
    halt_a = '0;
    check("t3b_status", 32'(status_a), 1);
    check("t3b_cyc", cyc_a, 100);

    // Stall watchdog: commits stop at cycle 50
    reset_a();
    step(50);
    commit_a = '0;
    step(15);
    check("t4_running65", 32'(running_a), 1);
    step(1);
    check("t4_done", 32'(done_a), 1);
    check("t4_status", 32'(status_a), 3);
    check("t4_cyc", cyc_a, 66);

    // Commit in the limit cycle keeps it running; next stall ends at 81
    reset_a();
    step(50);
    commit_a = '0;
    step(15);
    commit_a = 8'h04;
    step(1);
    commit_a = '0;
    check("t4b_running", 32'(running_a), 1);
    check("t4b_status", 32'(status_a), 0);
    step(15);
    check("t4b_running81", 32'(running_a), 1);
    step(1);
    check("t4b_status2", 32'(status_a), 3);
    check("t4b_cyc", cyc_a, 82);

    // Error pulse at 20, halt during drain ignored
    reset_a();
    step(20);
    err_a = 1'b1;
    step(1);
    err_a = 1'b0;
    check("t5_status", 32'(status_a), 4);
    check("t5_running", 32'(running_a), 0);
    check("t5_cyc", cyc_a, 21);
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) halt_a = '1;
      step(1);
      halt_a = '0;
      check($sformatf("t5_done_e%0d", i), 32'(done_a), (i == 5) ? 1 : 0);
    end
    check("t5_status_end", 32'(status_a), 4);
    check("t5_cyc_frozen", cyc_a, 21);

    // Same-cycle error and halt, then async reset mid-drain
    reset_a();
    step(10);
    err_a = 1'b1; halt_a = 8'h01;
    step(1);
    err_a = 1'b0; halt_a = '0;
    check("t6_status", 32'(status_a), 4);
    step(2);
    rst_a = 1'b1;
    #1;
    check("t6_async_dut_rst", 32'(dut_rst_a), 1);
    check("t6_async_status", 32'(status_a), 0);
    check("t6_async_cyc", cyc_a, 0);
    check("t6_async_running", 32'(running_a), 0);
    reset_a();

    // All-halt quorum with sticky pulses, stall disabled
    reset_b();
    step(10);
    halt_b = 4'b0001; step(1); halt_b = '0;
    step(9);
    halt_b = 4'b0100; step(1); halt_b = '0;
    step(9);
    halt_b = 4'b0010; step(1); halt_b = '0;
    step(3);
    check("t2_running34", 32'(running_b), 1);
    check("t2_status34", 32'(status_b), 0);
    step(1);
    halt_b = 4'b1000; step(1); halt_b = '0;
    check("t2_done", 32'(done_b), 1);
    check("t2_status", 32'(status_b), 1);
    check("t2_cyc", 32'(cyc_b), 36);

    // Cycle count saturation, then error with zero drain
    reset_b();
    step(70);
    check("sat_running", 32'(running_b), 1);
    check("sat_cyc", 32'(cyc_b), 63);
    err_b = 1'b1;
    step(1);
    err_b = 1'b0;
    check("sat_err_done", 32'(done_b), 1);
    check("sat_err_status", 32'(status_b), 4);
    check("sat_err_cyc", 32'(cyc_b), 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
